// File: rtl/dmem_sig_dumper.sv
// dmem_sig_dumper
//   End-of-test signature dumper for rv32im_top. It snoops the CPU store bus
//   for an end-of-test tohost store (bit 0 set) or a RUN-cycle timeout. On
//   either trigger it halts the core, reads DUMP_WORDS words from DMEM through
//   a spare read port (starting at word 0) and streams them out over a
//   valid/ready interface for signature comparison.
//
// Optional feature macro: SIG_CHECKSUM_EN
//   defined   : checksum_o is the 32-bit wrap-around sum of every transferred
//               signature word.
//   undefined : checksum_o is tied to zero.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high reset
//   st_en_i      in   CPU store strobe
//   st_addr_i    in   store byte address
//   st_data_i    in   store data
//   halt_o       out  stall request to the core, held until reset
//   rd_en_o      out  DMEM read enable (one cycle per word)
//   rd_addr_o    out  DMEM word index
//   rd_data_i    in   DMEM read data, valid one cycle after rd_en_o
//   sig_valid_o  out  signature word valid
//   sig_ready_i  in   consumer ready
//   sig_data_o   out  signature word
//   sig_idx_o    out  index of sig_data_o
//   done_o       out  every word transferred
//   timeout_o    out  dump was triggered by the cycle timeout
//   exit_code_o  out  st_data_i[31:1] of the triggering tohost store
//   checksum_o   out  running sum of transferred words (see macro above)
//
// States
//   RUN  | core running; watch stores and count cycles
//   READ | rd_en_o asserted for the current word index
//   CAPT | DMEM data returns; load the output register
//   SEND | sig_valid_o held until the consumer accepts the word
//   DONE | all words sent; terminal until reset

module dmem_sig_dumper #(
    parameter int          DMEM_SIZE_POW2 = 9,
    parameter logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] TOHOST_ADDR    = 32'h8000_01FC,
    parameter int          DUMP_WORDS     = 128,
    parameter int          TIMEOUT_CYCLES = 40000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          st_en_i,
    input  logic [31:0]                   st_addr_i,
    input  logic [31:0]                   st_data_i,
    output logic                          halt_o,
    output logic                          rd_en_o,
    output logic [DMEM_SIZE_POW2-3:0]     rd_addr_o,
    input  logic [31:0]                   rd_data_i,
    output logic                          sig_valid_o,
    input  logic                          sig_ready_i,
    output logic [31:0]                   sig_data_o,
    output logic [$clog2(DUMP_WORDS)-1:0] sig_idx_o,
    output logic                          done_o,
    output logic                          timeout_o,
    output logic [30:0]                   exit_code_o,
    output logic [31:0]                   checksum_o
);

    localparam int AW = DMEM_SIZE_POW2 - 2;
    localparam int IW = $clog2(DUMP_WORDS);
    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DUMP_WORDS - 1);

    // Reject configurations the dump cannot honour: more words than DMEM holds,
    // or a DMEM base that is not word aligned.
    generate
        if (DUMP_WORDS > (1 << AW) || DMEM_BASE_ADDR[1:0] != 2'b00) begin : g_cfg_err
            $error("dmem_sig_dumper: invalid DUMP_WORDS or DMEM_BASE_ADDR");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_READ = 3'd1,
        S_CAPT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          trig_a;
    logic          trig_b;
    logic          handshake;

    assign trig_a    = st_en_i && (st_addr_i == TOHOST_ADDR) && st_data_i[0];
    assign trig_b    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign handshake = sig_valid_o && sig_ready_i;

    assign rd_en_o   = (state == S_READ);
    assign rd_addr_o = AW'(idx);

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:  if (trig_a || trig_b) state_nxt = S_READ;
            S_READ: state_nxt = S_CAPT;
            S_CAPT: state_nxt = S_SEND;
            S_SEND: begin
                if (handshake) state_nxt = (idx == IDX_LAST) ? S_DONE : S_READ;
            end
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            cnt         <= '0;
            idx         <= '0;
            halt_o      <= 1'b0;
            sig_valid_o <= 1'b0;
            sig_data_o  <= '0;
            sig_idx_o   <= '0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
            exit_code_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_RUN: begin
                    if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
                    // A tohost store takes priority over a coincident timeout.
                    if (trig_a) begin
                        halt_o      <= 1'b1;
                        timeout_o   <= 1'b0;
                        exit_code_o <= st_data_i[31:1];
                    end else if (trig_b) begin
                        halt_o      <= 1'b1;
                        timeout_o   <= 1'b1;
                        exit_code_o <= '0;
                    end
                end
                S_CAPT: begin
                    sig_data_o  <= rd_data_i;
                    sig_idx_o   <= idx;
                    sig_valid_o <= 1'b1;
                end
                S_SEND: begin
                    if (handshake) begin
                        sig_valid_o <= 1'b0;
                        if (idx == IDX_LAST) done_o <= 1'b1;
                        else                 idx    <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SIG_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset)          checksum_o <= '0;
        else if (handshake) checksum_o <= checksum_o + sig_data_o;
    end
`else
    assign checksum_o = 32'h0;
`endif

endmodule
